// File: rtl/op_decoder_pipe.sv
// Registered instruction decoder sitting between IF and EX.
// Decodes the EX/MEM/WB control bundle, flags illegal encodings, counts them,
// and can hold off new instructions after a FENCE until data memory drains.
module op_decoder_pipe #(
    parameter int XLEN        = 32,
    parameter bit FENCE_BLOCK = 1'b1,
    parameter int CNT_W       = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_instr,
    input  logic [XLEN-1:0]  i_pc,
    input  logic             i_flush,
    input  logic             i_mem_idle,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_pc,
    output logic             o_jump_ID,
    output logic             o_branch_ID,
    output logic             o_reg_write_ID,
    output logic             o_mem_write_ID,
    output logic             o_alu_src_ID,
    output logic             o_addr_src_ID,
    output logic             o_fence_ID,
    output logic [1:0]       o_result_src_ID,
    output logic [2:0]       o_imm_src_ID,
    output logic [2:0]       o_alu_op,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_illegal_cnt
);

    localparam logic [4:0] OP_LOAD     = 5'b00000;
    localparam logic [4:0] OP_STORE    = 5'b01000;
    localparam logic [4:0] OP_OPIMM    = 5'b00100;
    localparam logic [4:0] OP_OP       = 5'b01100;
    localparam logic [4:0] OP_BRANCH   = 5'b11000;
    localparam logic [4:0] OP_JAL      = 5'b11011;
    localparam logic [4:0] OP_JALR     = 5'b11001;
    localparam logic [4:0] OP_LUI      = 5'b01101;
    localparam logic [4:0] OP_AUIPC    = 5'b00101;
    localparam logic [4:0] OP_MISC_MEM = 5'b00011;
    localparam logic [4:0] OP_SYSTEM   = 5'b11100;

    localparam logic [2:0] ALU_LUI     = 3'b000;
    localparam logic [2:0] ALU_ARITH   = 3'b001;
    localparam logic [2:0] ALU_ADD_SUB = 3'b010;
    localparam logic [2:0] ALU_BRANCH  = 3'b011;
    localparam logic [2:0] ALU_ADD     = 3'b100;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_PC4 = 2'b01;
    localparam logic [1:0] RES_MEM = 2'b10;
    localparam logic [1:0] RES_PCI = 2'b11;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    typedef enum logic {
        RUN,
        FENCE_WAIT
    } state_t;

    state_t state, state_next;

    logic [4:0] op;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       unused_instr_bits;

    logic       dec_jump, dec_branch, dec_reg_write, dec_mem_write;
    logic       dec_alu_src, dec_addr_src, dec_fence, dec_illegal;
    logic [1:0] dec_result_src;
    logic [2:0] dec_imm_src;
    logic [2:0] dec_alu_op;

    logic accept;
    logic take;

    assign op       = i_instr[6:2];
    assign funct3   = i_instr[14:12];
    assign funct7_5 = i_instr[30];
    assign unused_instr_bits = ^{i_instr[31], i_instr[29:15], i_instr[11:7]};

    // Ready is held low while in reset, so nothing is taken before the first edge after release.
    assign o_ready = i_rst_n && (state == RUN) && (!o_valid || i_ready);
    assign accept  = i_valid && o_ready;
    assign take    = accept && !i_flush;

    // Combinational decode of the incoming word; illegal encodings collapse to a quiet bundle.
    always_comb begin
        dec_jump       = 1'b0;
        dec_branch     = 1'b0;
        dec_reg_write  = 1'b0;
        dec_mem_write  = 1'b0;
        dec_alu_src    = 1'b0;
        dec_addr_src   = 1'b0;
        dec_fence      = 1'b0;
        dec_illegal    = 1'b0;
        dec_result_src = RES_ALU;
        dec_imm_src    = IMM_I;
        dec_alu_op     = ALU_ADD_SUB;

        if (i_instr[1:0] != 2'b11) begin
            dec_illegal = 1'b1;
        end else begin
            case (op)
                OP_LOAD: begin
                    dec_reg_write  = 1'b1;
                    dec_result_src = RES_MEM;
                    dec_alu_src    = 1'b1;
                    dec_imm_src    = IMM_I;
                    dec_alu_op     = ALU_ADD_SUB;
                end
                OP_STORE: begin
                    dec_mem_write = 1'b1;
                    dec_alu_src   = 1'b1;
                    dec_imm_src   = IMM_S;
                    dec_alu_op    = ALU_ADD_SUB;
                end
                OP_OPIMM: begin
                    dec_reg_write  = 1'b1;
                    dec_result_src = RES_ALU;
                    dec_alu_src    = 1'b1;
                    dec_imm_src    = IMM_I;
                    dec_alu_op     = ALU_ARITH;
                end
                OP_OP: begin
                    if (funct7_5 && (funct3 != 3'b000) && (funct3 != 3'b101)) begin
                        dec_illegal = 1'b1;
                    end else begin
                        dec_reg_write  = 1'b1;
                        dec_result_src = RES_ALU;
                        dec_alu_op     = (funct3 == 3'b000) ? ALU_ADD_SUB : ALU_ARITH;
                    end
                end
                OP_BRANCH: begin
                    dec_branch  = 1'b1;
                    dec_imm_src = IMM_B;
                    dec_alu_op  = ALU_BRANCH;
                end
                OP_JAL: begin
                    dec_jump       = 1'b1;
                    dec_reg_write  = 1'b1;
                    dec_result_src = RES_PC4;
                    dec_imm_src    = IMM_J;
                    dec_alu_op     = ALU_ADD;
                end
                OP_JALR: begin
                    dec_reg_write  = 1'b1;
                    dec_result_src = RES_PC4;
                    dec_alu_src    = 1'b1;
                    dec_addr_src   = 1'b1;
                    dec_imm_src    = IMM_I;
                    dec_alu_op     = ALU_ADD;
                end
                OP_LUI: begin
                    dec_reg_write  = 1'b1;
                    dec_result_src = RES_ALU;
                    dec_alu_src    = 1'b1;
                    dec_imm_src    = IMM_U;
                    dec_alu_op     = ALU_LUI;
                end
                OP_AUIPC: begin
                    dec_reg_write  = 1'b1;
                    dec_result_src = RES_PCI;
                    dec_alu_src    = 1'b1;
                    dec_imm_src    = IMM_U;
                    dec_alu_op     = ALU_ADD;
                end
                OP_MISC_MEM: begin
                    dec_fence  = 1'b1;
                    dec_alu_op = ALU_ADD_SUB;
                end
                OP_SYSTEM: begin
                    dec_reg_write = 1'b1;
                    dec_alu_src   = 1'b1;
                    dec_alu_op    = ALU_ADD_SUB;
                end
                default: dec_illegal = 1'b1;
            endcase
        end

        if (dec_illegal) begin
            dec_jump       = 1'b0;
            dec_branch     = 1'b0;
            dec_reg_write  = 1'b0;
            dec_mem_write  = 1'b0;
            dec_alu_src    = 1'b0;
            dec_addr_src   = 1'b0;
            dec_fence      = 1'b0;
            dec_result_src = RES_ALU;
            dec_imm_src    = IMM_I;
            dec_alu_op     = ALU_ADD_SUB;
        end
    end

    // FENCE drain state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= RUN;
        else          state <= state_next;
    end

    // Next state: flush always returns to RUN, otherwise wait out memory after a blocking FENCE.
    always_comb begin
        state_next = state;
        if (i_flush) begin
            state_next = RUN;
        end else begin
            case (state)
                RUN:        if (take && dec_fence && FENCE_BLOCK) state_next = FENCE_WAIT;
                FENCE_WAIT: if (i_mem_idle) state_next = RUN;
                default:    state_next = RUN;
            endcase
        end
    end

    // ID/EX output register: load on accept, drop valid on handoff, hold while EX stalls.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid         <= 1'b0;
            o_pc            <= '0;
            o_jump_ID       <= 1'b0;
            o_branch_ID     <= 1'b0;
            o_reg_write_ID  <= 1'b0;
            o_mem_write_ID  <= 1'b0;
            o_alu_src_ID    <= 1'b0;
            o_addr_src_ID   <= 1'b0;
            o_fence_ID      <= 1'b0;
            o_result_src_ID <= 2'b00;
            o_imm_src_ID    <= 3'b000;
            o_alu_op        <= 3'b000;
            o_illegal       <= 1'b0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end else if (take) begin
            o_valid         <= 1'b1;
            o_pc            <= i_pc;
            o_jump_ID       <= dec_jump;
            o_branch_ID     <= dec_branch;
            o_reg_write_ID  <= dec_reg_write;
            o_mem_write_ID  <= dec_mem_write;
            o_alu_src_ID    <= dec_alu_src;
            o_addr_src_ID   <= dec_addr_src;
            o_fence_ID      <= dec_fence;
            o_result_src_ID <= dec_result_src;
            o_imm_src_ID    <= dec_imm_src;
            o_alu_op        <= dec_alu_op;
            o_illegal       <= dec_illegal;
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end
    end

    // Saturating count of illegal instructions that were actually taken (flushed ones don't count).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_illegal_cnt <= '0;
        end else if (take && dec_illegal && (o_illegal_cnt != {CNT_W{1'b1}})) begin
            o_illegal_cnt <= o_illegal_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_op_decoder_pipe.sv
// Directed bench for op_decoder_pipe: a default instance (blocking FENCE, 8-bit counter)
// and a small instance (non-blocking FENCE, 2-bit counter) for saturation.
module tb_op_decoder_pipe;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid, i_flush, i_mem_idle, i_ready;
    logic [31:0] i_instr, i_pc;
    logic        o_ready, o_valid;
    logic [31:0] o_pc;
    logic        o_jump_ID, o_branch_ID, o_reg_write_ID, o_mem_write_ID;
    logic        o_alu_src_ID, o_addr_src_ID, o_fence_ID, o_illegal;
    logic [1:0]  o_result_src_ID;
    logic [2:0]  o_imm_src_ID, o_alu_op;
    logic [7:0]  o_illegal_cnt;

    logic        i_valid2;
    logic [31:0] i_instr2;
    logic        o_ready2, o_valid2;
    logic [31:0] o_pc2;
    logic        o_jump2, o_branch2, o_reg_write2, o_mem_write2;
    logic        o_alu_src2, o_addr_src2, o_fence2, o_illegal2;
    logic [1:0]  o_result_src2;
    logic [2:0]  o_imm_src2, o_alu_op2;
    logic [1:0]  o_illegal_cnt2;

    logic [15:0] act_ctl;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] ADDI   = 32'h00500093;
    localparam logic [31:0] LW     = 32'h0000A103;
    localparam logic [31:0] SW     = 32'h0020A223;
    localparam logic [31:0] JAL    = 32'h008000EF;
    localparam logic [31:0] FENCE  = 32'h0FF0000F;
    localparam logic [31:0] SUB    = 32'h40208033;
    localparam logic [31:0] SRA    = 32'h4020D033;
    localparam logic [31:0] BADSLL = 32'h40209033;

    always #5 i_clk = ~i_clk;

    op_decoder_pipe dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_instr(i_instr), .i_pc(i_pc), .i_flush(i_flush), .i_mem_idle(i_mem_idle),
        .o_valid(o_valid), .i_ready(i_ready), .o_pc(o_pc),
        .o_jump_ID(o_jump_ID), .o_branch_ID(o_branch_ID), .o_reg_write_ID(o_reg_write_ID),
        .o_mem_write_ID(o_mem_write_ID), .o_alu_src_ID(o_alu_src_ID), .o_addr_src_ID(o_addr_src_ID),
        .o_fence_ID(o_fence_ID), .o_result_src_ID(o_result_src_ID), .o_imm_src_ID(o_imm_src_ID),
        .o_alu_op(o_alu_op), .o_illegal(o_illegal), .o_illegal_cnt(o_illegal_cnt)
    );

    op_decoder_pipe #(.XLEN(32), .FENCE_BLOCK(1'b0), .CNT_W(2)) dut_small (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid2), .o_ready(o_ready2),
        .i_instr(i_instr2), .i_pc(32'h0000_1000), .i_flush(1'b0), .i_mem_idle(1'b0),
        .o_valid(o_valid2), .i_ready(1'b1), .o_pc(o_pc2),
        .o_jump_ID(o_jump2), .o_branch_ID(o_branch2), .o_reg_write_ID(o_reg_write2),
        .o_mem_write_ID(o_mem_write2), .o_alu_src_ID(o_alu_src2), .o_addr_src_ID(o_addr_src2),
        .o_fence_ID(o_fence2), .o_result_src_ID(o_result_src2), .o_imm_src_ID(o_imm_src2),
        .o_alu_op(o_alu_op2), .o_illegal(o_illegal2), .o_illegal_cnt(o_illegal_cnt2)
    );

    assign act_ctl = {o_jump_ID, o_branch_ID, o_reg_write_ID, o_mem_write_ID, o_alu_src_ID,
                      o_addr_src_ID, o_fence_ID, o_result_src_ID, o_imm_src_ID, o_alu_op, o_illegal};

    // Pack an expected control bundle in the same order as act_ctl.
    function automatic logic [15:0] ctl(input logic j, input logic b, input logic rw, input logic mw,
                                        input logic as, input logic ads, input logic f,
                                        input logic [1:0] rs, input logic [2:0] imm,
                                        input logic [2:0] alu, input logic ill);
        return {j, b, rw, mw, as, ads, f, rs, imm, alu, ill};
    endfunction

    // One immediate-assertion comparison point.
    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic valid, input logic [31:0] instr, input logic [31:0] pc);
        i_valid = valid;
        i_instr = instr;
        i_pc    = pc;
    endtask

    // Linear sequence of directed steps.
    initial begin
        logic [31:0] vec_instr [6];
        logic [15:0] vec_ctl   [6];
        logic [15:0] ctl_ill;

        ctl_ill = ctl(0,0,0,0,0,0,0,2'b00,3'b000,3'b010,1);
        vec_instr[0] = 32'h00208463; vec_ctl[0] = ctl(0,1,0,0,0,0,0,2'b00,3'b010,3'b011,0);
        vec_instr[1] = 32'h123450B7; vec_ctl[1] = ctl(0,0,1,0,1,0,0,2'b00,3'b100,3'b000,0);
        vec_instr[2] = 32'h00001097; vec_ctl[2] = ctl(0,0,1,0,1,0,0,2'b11,3'b100,3'b100,0);
        vec_instr[3] = 32'h000080E7; vec_ctl[3] = ctl(0,0,1,0,1,1,0,2'b01,3'b000,3'b100,0);
        vec_instr[4] = 32'h00000073; vec_ctl[4] = ctl(0,0,1,0,1,0,0,2'b00,3'b000,3'b010,0);
        vec_instr[5] = 32'h002081B3; vec_ctl[5] = ctl(0,0,1,0,0,0,0,2'b00,3'b000,3'b010,0);

        i_rst_n = 1'b0; i_flush = 1'b0; i_mem_idle = 1'b0; i_ready = 1'b1;
        i_valid2 = 1'b0; i_instr2 = 32'h0;
        drive(1'b0, 32'h0, 32'h0);
        $display("[TB] reset");
        #2;
        check_output("reset_valid", 64'(o_valid), 64'd0);
        check_output("reset_ready", 64'(o_ready), 64'd0);
        check_output("reset_ctl",   64'(act_ctl), 64'd0);
        check_output("reset_cnt",   64'(o_illegal_cnt), 64'd0);
        tick(); tick();
        i_rst_n = 1'b1;
        #1;
        check_output("ready_after_release", 64'(o_ready), 64'd1);

        $display("[TB] ADDI");
        drive(1'b1, ADDI, 32'h100);
        tick();
        check_output("addi_valid", 64'(o_valid), 64'd1);
        check_output("addi_ctl",   64'(act_ctl), 64'(ctl(0,0,1,0,1,0,0,2'b00,3'b000,3'b001,0)));
        check_output("addi_pc",    64'(o_pc), 64'h100);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        check_output("addi_drained", 64'(o_valid), 64'd0);

        $display("[TB] stream with stall");
        drive(1'b1, LW, 32'h200);
        tick();
        check_output("lw_ctl", 64'(act_ctl), 64'(ctl(0,0,1,0,1,0,0,2'b10,3'b000,3'b010,0)));
        i_ready = 1'b0;
        drive(1'b1, SW, 32'h204);
        #1;
        check_output("stall_ready", 64'(o_ready), 64'd0);
        for (int k = 0; k < 2; k++) begin
            tick();
            check_output("stall_hold_pc",  64'(o_pc), 64'h200);
            check_output("stall_hold_ctl", 64'(act_ctl), 64'(ctl(0,0,1,0,1,0,0,2'b10,3'b000,3'b010,0)));
            check_output("stall_hold_vld", 64'(o_valid), 64'd1);
        end
        i_ready = 1'b1;
        #1;
        check_output("unstall_ready", 64'(o_ready), 64'd1);
        tick();
        check_output("sw_pc",  64'(o_pc), 64'h204);
        check_output("sw_ctl", 64'(act_ctl), 64'(ctl(0,0,0,1,1,0,0,2'b00,3'b001,3'b010,0)));
        drive(1'b1, JAL, 32'h208);
        tick();
        check_output("jal_pc",  64'(o_pc), 64'h208);
        check_output("jal_ctl", 64'(act_ctl), 64'(ctl(1,0,1,0,0,0,0,2'b01,3'b011,3'b100,0)));
        drive(1'b0, 32'h0, 32'h0);
        tick();
        check_output("stream_drained", 64'(o_valid), 64'd0);

        $display("[TB] FENCE drain");
        drive(1'b1, FENCE, 32'h300);
        tick();
        check_output("fence_ctl", 64'(act_ctl), 64'(ctl(0,0,0,0,0,0,1,2'b00,3'b000,3'b010,0)));
        drive(1'b1, ADDI, 32'h304);
        #1;
        for (int k = 0; k < 5; k++) begin
            check_output("fence_wait_ready", 64'(o_ready), 64'd0);
            check_output("fence_wait_valid", 64'(o_valid), (k == 0) ? 64'd1 : 64'd0);
            tick();
        end
        i_mem_idle = 1'b1;
        #1;
        check_output("fence_idle_cycle_ready", 64'(o_ready), 64'd0);
        tick();
        check_output("fence_released_ready", 64'(o_ready), 64'd1);
        tick();
        check_output("post_fence_pc",  64'(o_pc), 64'h304);
        check_output("post_fence_vld", 64'(o_valid), 64'd1);
        i_mem_idle = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        tick();

        $display("[TB] illegal detection");
        drive(1'b1, 32'h0000_0000, 32'h400);
        tick();
        check_output("ill_zero_ctl", 64'(act_ctl), 64'(ctl_ill));
        check_output("ill_zero_cnt", 64'(o_illegal_cnt), 64'd1);
        drive(1'b1, 32'hFFFF_FFFF, 32'h404);
        tick();
        check_output("ill_ones_ctl", 64'(act_ctl), 64'(ctl_ill));
        check_output("ill_ones_cnt", 64'(o_illegal_cnt), 64'd2);
        drive(1'b1, BADSLL, 32'h408);
        tick();
        check_output("ill_f7_ctl", 64'(act_ctl), 64'(ctl_ill));
        check_output("ill_f7_cnt", 64'(o_illegal_cnt), 64'd3);
        drive(1'b1, SRA, 32'h40C);
        tick();
        check_output("sra_ctl", 64'(act_ctl), 64'(ctl(0,0,1,0,0,0,0,2'b00,3'b000,3'b001,0)));
        check_output("sra_cnt", 64'(o_illegal_cnt), 64'd3);
        drive(1'b0, 32'h0, 32'h0);
        tick();

        $display("[TB] flush");
        i_flush = 1'b1;
        drive(1'b1, SUB, 32'h500);
        tick();
        check_output("flush_sub_valid", 64'(o_valid), 64'd0);
        drive(1'b1, 32'h0, 32'h504);
        tick();
        check_output("flush_ill_valid", 64'(o_valid), 64'd0);
        check_output("flush_ill_cnt",   64'(o_illegal_cnt), 64'd3);
        i_flush = 1'b0;
        drive(1'b1, LW, 32'h508);
        tick();
        check_output("pre_flush_held", 64'(o_valid), 64'd1);
        drive(1'b0, 32'h0, 32'h0);
        i_ready = 1'b0;
        i_flush = 1'b1;
        tick();
        check_output("flush_stalled_valid", 64'(o_valid), 64'd0);
        i_flush = 1'b0;
        i_ready = 1'b1;

        drive(1'b1, FENCE, 32'h600);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        tick();
        check_output("fence2_wait_ready", 64'(o_ready), 64'd0);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        #1;
        check_output("flush_fence_ready", 64'(o_ready), 64'd1);

        $display("[TB] async reset mid FENCE_WAIT");
        i_ready = 1'b0;
        drive(1'b1, FENCE, 32'h700);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        check_output("pre_reset_valid", 64'(o_valid), 64'd1);
        check_output("pre_reset_ready", 64'(o_ready), 64'd0);
        #2;
        i_rst_n = 1'b0;
        #1;
        check_output("async_reset_valid", 64'(o_valid), 64'd0);
        check_output("async_reset_ctl",   64'(act_ctl), 64'd0);
        check_output("async_reset_pc",    64'(o_pc), 64'd0);
        check_output("async_reset_cnt",   64'(o_illegal_cnt), 64'd0);
        tick();
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        #1;
        check_output("rerelease_ready", 64'(o_ready), 64'd1);

        $display("[TB] remaining opcodes");
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, vec_instr[k], 32'h800 + 32'(k * 4));
            tick();
            check_output("opcode_ctl", 64'(act_ctl), 64'(vec_ctl[k]));
            check_output("opcode_pc",  64'(o_pc), 64'(32'h800 + 32'(k * 4)));
        end
        drive(1'b0, 32'h0, 32'h0);
        tick();

        $display("[TB] small instance: saturation and non-blocking FENCE");
        i_valid2 = 1'b1;
        i_instr2 = 32'h0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check_output("sat_cnt", 64'(o_illegal_cnt2), (k < 3) ? 64'(k) : 64'd3);
        end
        i_instr2 = FENCE;
        tick();
        check_output("nb_fence_flag",  64'(o_fence2), 64'd1);
        check_output("nb_fence_ready", 64'(o_ready2), 64'd1);
        i_instr2 = ADDI;
        tick();
        check_output("nb_after_fence_valid", 64'(o_valid2), 64'd1);
        check_output("nb_after_fence_alu",   64'(o_alu_op2), 64'd1);
        i_valid2 = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/op_decoder_pipe.md
Name: op_decoder_pipe

Overview:
Registered, handshaked successor to the combinational opcode decoder. It accepts a fetched instruction and its PC from IF, decodes the control bundle for EX/MEM/WB, and holds the result in an ID/EX output register with valid/ready flow control. Over the combinational decoder it adds flush, illegal-instruction detection, a saturating illegal counter, and a FENCE drain state machine.

Parameters:
XLEN, 32, width of PC passthrough
FENCE_BLOCK, 1, 1: stall after FENCE until memory idle; 0: FENCE decodes as a normal op
CNT_W, 8, width of the illegal-instruction counter

Ports:
i_clk  in  1  clock
i_rst_n  in  1  async active-low reset
i_valid  in  1  upstream instruction valid
o_ready  out  1  block can accept an instruction this cycle
i_instr  in  32  instruction word
i_pc  in  XLEN  instruction PC
i_flush  in  1  kill the held instruction and abort FENCE wait
i_mem_idle  in  1  data memory has no outstanding accesses
o_valid  out  1  output bundle valid
i_ready  in  1  EX accepts the bundle
o_pc  out  XLEN  registered PC
o_jump_ID, o_branch_ID, o_reg_write_ID, o_mem_write_ID, o_alu_src_ID, o_addr_src_ID, o_fence_ID  out  1 each  control flags
o_result_src_ID  out  2  00 ALU, 01 PC+4, 10 memory, 11 PC+imm
o_imm_src_ID  out  3  000 I, 001 S, 010 B, 011 J, 100 U
o_alu_op  out  3  000 LUI, 001 ARITH, 010 ADD_SUB, 011 BRANCH, 100 ADD
o_illegal  out  1  held instruction is illegal
o_illegal_cnt  out  CNT_W  saturating count of accepted illegal instructions

Behaviour:
- Reset (async, i_rst_n=0): all outputs 0, FSM in RUN, counter 0. o_ready is 0 during reset and 1 in the first cycle after release.
- op = i_instr[6:2].
  - LOAD 00000: reg_write, result 10, alu_src, imm I, ADD_SUB.
  - STORE 01000: mem_write, alu_src, imm S, ADD_SUB.
  - OP-IMM 00100: reg_write, result 00, alu_src, imm I, ARITH.
  - OP 01100: reg_write, result 00; alu_op ADD_SUB if funct3=000, else ARITH.
  - BRANCH 11000: branch, imm B, BRANCH.
  - JAL 11011: jump, reg_write, result 01, imm J, ADD.
  - JALR 11001: reg_write, result 01, alu_src, addr_src, imm I, ADD.
  - LUI 01101: reg_write, result 00, alu_src, imm U, LUI.
  - AUIPC 00101: reg_write, result 11, alu_src, imm U, ADD.
  - MISC-MEM 00011: fence, ADD_SUB.
  - SYSTEM 11100: reg_write, alu_src, ADD_SUB.
- Illegal: i_instr[1:0]≠11, or op not in the list above, or funct7[5]=1 on OP with funct3∉{000,101}. Result: o_illegal=1, all other control flags and fields 0, o_alu_op=ADD_SUB.
- Accept when i_valid && o_ready. The bundle is registered, so it appears on the outputs with 1-cycle latency.
- o_ready = state==RUN && (!o_valid || i_ready). Back-to-back throughput is one instruction per cycle.
- Output register: if a new instruction is accepted, load it and set o_valid=1. Else if o_valid && i_ready, clear o_valid. While o_valid && !i_ready, all outputs stay stable.
- o_illegal_cnt increments on each accepted illegal instruction and saturates at 2^CNT_W−1.
- FSM states: RUN, FENCE_WAIT.
  - RUN→FENCE_WAIT on accepting a FENCE when FENCE_BLOCK=1.
  - FENCE_WAIT→RUN in the first cycle i_mem_idle=1; o_ready rises the cycle after.
  - FENCE_BLOCK=0: FSM never leaves RUN.
- i_flush: highest priority. Next cycle o_valid=0 and state=RUN, and any same-cycle accept is discarded. The counter is not incremented for a discarded accept. Flush does not clear o_illegal_cnt.
- A flush coincident with i_mem_idle yields RUN; there is no double transition.
- Reset mid-FENCE_WAIT or with o_valid=1 returns the block to the reset state immediately.

Test Plan:
- Reset release, then ADDI 0x00500093 with i_valid=1, i_ready=1 → next cycle o_valid=1, reg_write=1, alu_src=1, alu_op=001, imm_src=000, result_src=00.
- Stream LW 0x0000A103, SW 0x0020A223, JAL 0x008000EF on consecutive cycles with i_ready held 0 for 2 cycles after the first → LW bundle held stable, o_ready=0 while stalled, no instruction lost or duplicated, then 1/cycle.
- FENCE 0x0FF0000F with i_mem_idle=0 for 5 cycles → o_fence_ID=1 next cycle, o_ready=0 for 5 cycles, rises the cycle after i_mem_idle=1.
- Illegal 0x00000000, then 0xFFFFFFFF → o_illegal=1, all enables 0, o_illegal_cnt=2. With CNT_W=2, 5 illegals → count 3.
- i_flush asserted in the same cycle as accepting SUB 0x40208033 → next cycle o_valid=0, counter unchanged. i_flush during FENCE_WAIT → state RUN, o_ready=1 next cycle.
- Assert i_rst_n=0 during FENCE_WAIT with o_valid=1 → all outputs 0 immediately (asynchronous), FSM RUN, counter 0.
